// File: rtl/timer_counter_if.sv
// rtl/timer_counter_if.sv - bridge-to-timer register bus with the interrupt line back to the bridge.
interface timer_counter_if;
  logic [29:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  modport master (output Addr, WE, Din, input Dout, IRQ);
  modport slave  (input Addr, WE, Din, output Dout, IRQ);
endinterface

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - memory-mapped 32-bit down-counter timer with one-shot/auto-reload IRQ.
// Optional prescaler register at offset 3 is built only when TC_PRESCALE_EN is defined.
module timer_counter #(
  parameter int PRESCALE_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  timer_counter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_e;

  state_e      state_q;
  logic [3:0]  ctrl_q;
  logic [31:0] preset_q;
  logic [31:0] count_q;
  logic        irq_flag_q;

  logic [1:0]  sel;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        tick;
  logic        unused_addr;

  assign sel         = bus.Addr[3:2];
  assign wr_ctrl     = bus.WE && (sel == 2'd0);
  assign wr_preset   = bus.WE && (sel == 2'd1);
  assign unused_addr = ^{bus.Addr[29:4], bus.Addr[1:0]};

`ifdef TC_PRESCALE_EN
  logic [PRESCALE_W-1:0] prescale_q;
  logic [PRESCALE_W-1:0] pcnt_q;
  logic                  wr_prescale;

  assign wr_prescale = bus.WE && (sel == 2'd3);
  assign tick        = (pcnt_q == prescale_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      prescale_q <= '0;
      pcnt_q     <= '0;
    end else begin
      if (wr_prescale) prescale_q <= bus.Din[PRESCALE_W-1:0];
      if (state_q == LOAD) begin
        pcnt_q <= '0;
      end else if (state_q == CNT && ctrl_q[0]) begin
        pcnt_q <= tick ? '0 : pcnt_q + 1'b1;
      end
    end
  end
`else
  assign tick = 1'b1;
`endif

  // Case assignments come after the bus write so FSM-set irq_flag beats a CTRL-write clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ctrl_q     <= 4'd0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
    end else begin
      if (wr_preset) preset_q <= bus.Din;
      if (wr_ctrl) begin
        ctrl_q     <= bus.Din[3:0];
        irq_flag_q <= 1'b0;
      end
      case (state_q)
        IDLE: if (ctrl_q[0]) state_q <= LOAD;
        LOAD: begin
          count_q <= preset_q;
          state_q <= CNT;
        end
        CNT: begin
          if (!ctrl_q[0]) begin
            state_q <= IDLE;
          end else if (tick) begin
            if (count_q > 32'd1) begin
              count_q <= count_q - 32'd1;
            end else begin
              count_q    <= 32'd0;
              irq_flag_q <= 1'b1;
              state_q    <= INT;
            end
          end
        end
        INT: begin
          if (ctrl_q[2:1] == 2'b01) begin
            irq_flag_q <= 1'b0;
            state_q    <= LOAD;
          end else begin
            if (!wr_ctrl) ctrl_q[0] <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.Dout = 32'd0;
    case (sel)
      2'd0: bus.Dout = {28'd0, ctrl_q};
      2'd1: bus.Dout = preset_q;
      2'd2: bus.Dout = count_q;
`ifdef TC_PRESCALE_EN
      2'd3: bus.Dout = {{(32-PRESCALE_W){1'b0}}, prescale_q};
`endif
      default: bus.Dout = 32'd0;
    endcase
  end

  assign bus.IRQ = irq_flag_q & ctrl_q[3];

endmodule
